// File: rtl/stage_memory.sv
// Memory pipeline stage: Avalon-MM initiator for scalar and 4-beat vector
// loads/stores, plus the writeback pipeline register.
module stage_memory #(
    parameter int unsigned BEATS_VEC   = 4,
    parameter int unsigned ADDR_STRIDE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_reg_write,
    input  logic         mem_mem_read,
    input  logic         mem_mem_write,
    input  logic [1:0]   mem_result_src,
    input  logic         mem_vector_op,
    input  logic [127:0] mem_alu_result,
    input  logic [127:0] mem_write_data,
    input  logic [4:0]   mem_rd,
    input  logic [31:0]  mem_pc_plus_4,
    output logic         mem_stall,
    output logic [31:0]  avm_address,
    output logic         avm_read,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    input  logic         avm_waitrequest,
    input  logic [31:0]  avm_readdata,
    input  logic         avm_readdatavalid,
    output logic [127:0] wb_result,
    output logic         wb_reg_write,
    output logic [4:0]   wb_rd
);

    localparam int unsigned LANE_W = 32;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REQ    = 2'd1;
    localparam logic [1:0] RDWAIT = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [1:0] LAST_VEC = 2'(BEATS_VEC - 1);

    logic [1:0]   state, state_n;
    logic [1:0]   beat, beat_n, beat_inc;
    logic [127:0] ldbuf, ldbuf_n;
    logic [31:0]  address_n, writedata_n;
    logic         read_n, write_n;
    logic [127:0] wb_result_n;
    logic         wb_reg_write_n;
    logic [4:0]   wb_rd_n;
    logic         memop, last_beat;
    logic [31:0]  next_address, next_lane;

    assign memop     = mem_mem_read | mem_mem_write;
    assign mem_stall = memop & (state != DONE);
    assign last_beat = mem_vector_op ? (beat == LAST_VEC) : (beat == 2'd0);
    assign beat_inc  = beat + 2'd1;
    assign next_address = mem_alu_result[31:0] + 32'(ADDR_STRIDE) * 32'(beat_inc);

    // Store lane for the beat that follows the current one
    always_comb begin
        next_lane = mem_write_data[31:0];
        for (int i = 0; i < int'(BEATS_VEC); i++) begin
            if (beat_inc == 2'(i)) next_lane = mem_write_data[LANE_W*i +: LANE_W];
        end
    end

    // Next-state, request and writeback logic
    always_comb begin
        state_n        = state;
        beat_n         = beat;
        ldbuf_n        = ldbuf;
        address_n      = avm_address;
        read_n         = avm_read;
        write_n        = avm_write;
        writedata_n    = avm_writedata;
        wb_result_n    = 128'd0;
        wb_reg_write_n = 1'b0;
        wb_rd_n        = 5'd0;

        case (state)
            IDLE: begin
                if (memop) begin
                    beat_n      = 2'd0;
                    ldbuf_n     = 128'd0;
                    state_n     = REQ;
                    address_n   = mem_alu_result[31:0];
                    write_n     = mem_mem_write;
                    read_n      = ~mem_mem_write;
                    writedata_n = mem_write_data[31:0];
                end
            end
            REQ: begin
                if (!avm_waitrequest) begin
                    if (mem_mem_write) begin
                        if (last_beat) begin
                            write_n = 1'b0;
                            state_n = DONE;
                        end else begin
                            beat_n      = beat_inc;
                            address_n   = next_address;
                            writedata_n = next_lane;
                        end
                    end else begin
                        read_n  = 1'b0;
                        state_n = RDWAIT;
                    end
                end
            end
            RDWAIT: begin
                if (avm_readdatavalid) begin
                    for (int i = 0; i < int'(BEATS_VEC); i++) begin
                        if (beat == 2'(i)) ldbuf_n[LANE_W*i +: LANE_W] = avm_readdata;
                    end
                    if (last_beat) begin
                        state_n = DONE;
                    end else begin
                        beat_n    = beat_inc;
                        read_n    = 1'b1;
                        address_n = next_address;
                        state_n   = REQ;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A stalled instruction leaves a bubble in writeback
        if (!mem_stall) begin
            wb_reg_write_n = mem_reg_write;
            wb_rd_n        = mem_rd;
            case (mem_result_src)
                2'b01:   wb_result_n = ldbuf;
                2'b10:   wb_result_n = {96'd0, mem_pc_plus_4};
                default: wb_result_n = mem_alu_result;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            beat          <= 2'd0;
            ldbuf         <= 128'd0;
            avm_address   <= 32'd0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= 32'd0;
            wb_result     <= 128'd0;
            wb_reg_write  <= 1'b0;
            wb_rd         <= 5'd0;
        end else begin
            state         <= state_n;
            beat          <= beat_n;
            ldbuf         <= ldbuf_n;
            avm_address   <= address_n;
            avm_read      <= read_n;
            avm_write     <= write_n;
            avm_writedata <= writedata_n;
            wb_result     <= wb_result_n;
            wb_reg_write  <= wb_reg_write_n;
            wb_rd         <= wb_rd_n;
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// Directed self-checking bench for stage_memory: reset, ALU/link writeback,
// scalar and vector loads/stores over a hand-driven Avalon-MM target.
module tb_stage_memory;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_reg_write, mem_mem_read, mem_mem_write, mem_vector_op;
    logic [1:0]   mem_result_src;
    logic [127:0] mem_alu_result, mem_write_data;
    logic [4:0]   mem_rd;
    logic [31:0]  mem_pc_plus_4;
    logic         mem_stall;
    logic [31:0]  avm_address, avm_writedata, avm_readdata;
    logic         avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
    logic [127:0] wb_result;
    logic         wb_reg_write;
    logic [4:0]   wb_rd;

    int tests = 0;
    int fails = 0;

    int          rd_acc = 0;
    int          wr_acc = 0;
    logic [31:0] rd_addr_last = 32'd0;
    logic [31:0] wr_addr_log [32];
    logic [31:0] wr_data_log [32];

    always #5 clk = ~clk;

    stage_memory dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mem_reg_write     (mem_reg_write),
        .mem_mem_read      (mem_mem_read),
        .mem_mem_write     (mem_mem_write),
        .mem_result_src    (mem_result_src),
        .mem_vector_op     (mem_vector_op),
        .mem_alu_result    (mem_alu_result),
        .mem_write_data    (mem_write_data),
        .mem_rd            (mem_rd),
        .mem_pc_plus_4     (mem_pc_plus_4),
        .mem_stall         (mem_stall),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .wb_result         (wb_result),
        .wb_reg_write      (wb_reg_write),
        .wb_rd             (wb_rd)
    );

    // Log every accepted Avalon transfer
    always @(posedge clk) begin
        if (rst_n && avm_read && !avm_waitrequest) begin
            rd_acc       = rd_acc + 1;
            rd_addr_last = avm_address;
        end
        if (rst_n && avm_write && !avm_waitrequest) begin
            wr_addr_log[wr_acc % 32] = avm_address;
            wr_data_log[wr_acc % 32] = avm_writedata;
            wr_acc = wr_acc + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_reg_write     = 1'b0;
        mem_mem_read      = 1'b0;
        mem_mem_write     = 1'b0;
        mem_vector_op     = 1'b0;
        mem_result_src    = 2'b00;
        mem_alu_result    = 128'd0;
        mem_write_data    = 128'd0;
        mem_rd            = 5'd0;
        mem_pc_plus_4     = 32'd0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'd0;
    endtask

    initial begin
        int          cyc;
        int          rd_base;
        int          wr_base;
        logic [31:0] vals [4];
        logic [31:0] exp_addr;
        logic [31:0] exp_data;

        rst_n           = 1'b0;
        avm_waitrequest = 1'b0;
        idle_inputs();
        repeat (2) tick();
        check("rst_wb_reg_write", 128'(wb_reg_write), 128'd0);
        check("rst_wb_result", wb_result, 128'd0);

        // Vector store stuck in REQ, then reset mid-transaction
        rst_n          = 1'b1;
        mem_mem_write  = 1'b1;
        mem_vector_op  = 1'b1;
        mem_alu_result = 128'h200;
        mem_write_data = {32'h44, 32'h33, 32'h22, 32'h11};
        avm_waitrequest = 1'b1;
        #1;
        check("vst_stall_idle", 128'(mem_stall), 128'd1);
        tick();
        check("vst_req_write", 128'(avm_write), 128'd1);
        check("vst_req_addr", 128'(avm_address), 128'h200);
        tick();
        check("vst_hold_data", 128'(avm_writedata), 128'h11);
        rst_n = 1'b0;
        tick();
        check("rst_mid_write", 128'(avm_write), 128'd0);
        check("rst_mid_addr", 128'(avm_address), 128'd0);
        check("rst_mid_wb", 128'(wb_reg_write), 128'd0);
        check("rst_mid_state", 128'(dut.state), 128'd0);
        rst_n = 1'b1;
        avm_waitrequest = 1'b0;
        idle_inputs();
        #1;
        check("rst_nomem_stall", 128'(mem_stall), 128'd0);

        // ALU passthrough
        mem_reg_write  = 1'b1;
        mem_rd         = 5'd7;
        mem_alu_result = 128'hDEAD;
        #1;
        check("alu_stall", 128'(mem_stall), 128'd0);
        tick();
        check("alu_wb_rd", 128'(wb_rd), 128'd7);
        check("alu_wb_result", wb_result, 128'hDEAD);
        check("alu_wb_we", 128'(wb_reg_write), 128'd1);
        mem_result_src = 2'b11;
        mem_alu_result = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        tick();
        check("src11_wb_result", wb_result, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);

        // Scalar load, two waitrequest cycles
        idle_inputs();
        mem_mem_read    = 1'b1;
        mem_reg_write   = 1'b1;
        mem_rd          = 5'd5;
        mem_result_src  = 2'b01;
        mem_alu_result  = 128'h100;
        avm_waitrequest = 1'b1;
        rd_base = rd_acc;
        tick();
        check("ld_req_read", 128'(avm_read), 128'd1);
        check("ld_req_addr", 128'(avm_address), 128'h100);
        tick();
        check("ld_wait_read", 128'(avm_read), 128'd1);
        check("ld_wait_stall", 128'(mem_stall), 128'd1);
        tick();
        avm_waitrequest = 1'b0;
        tick();
        check("ld_rdwait_read", 128'(avm_read), 128'd0);
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'h1234_5678;
        tick();
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'd0;
        #1;
        check("ld_done_stall", 128'(mem_stall), 128'd0);
        check("ld_bubble", 128'(wb_reg_write), 128'd0);
        tick();
        check("ld_wb_result", wb_result, 128'h1234_5678);
        check("ld_wb_rd", 128'(wb_rd), 128'd5);
        check("ld_wb_we", 128'(wb_reg_write), 128'd1);
        check("ld_read_count", 128'(rd_acc - rd_base), 128'd1);
        check("ld_read_addr", 128'(rd_addr_last), 128'h100);
        idle_inputs();
        tick();

        // Vector store, zero-wait
        mem_mem_write  = 1'b1;
        mem_vector_op  = 1'b1;
        mem_alu_result = 128'h200;
        mem_write_data = {32'h44, 32'h33, 32'h22, 32'h11};
        mem_rd         = 5'd3;
        wr_base = wr_acc;
        #1;
        cyc = 0;
        while (mem_stall && cyc < 20) begin
            tick();
            cyc++;
        end
        check("vst_occupancy", 128'(cyc + 1), 128'd6);
        tick();
        check("vst_wb_we", 128'(wb_reg_write), 128'd0);
        check("vst_write_count", 128'(wr_acc - wr_base), 128'd4);
        for (int i = 0; i < 4; i++) begin
            exp_addr = 32'h200 + 32'(4 * i);
            exp_data = 32'h11 * 32'(i + 1);
            check("vst_addr", 128'(wr_addr_log[(wr_base + i) % 32]), 128'(exp_addr));
            check("vst_data", 128'(wr_data_log[(wr_base + i) % 32]), 128'(exp_data));
        end

        // Vector load, one waitrequest cycle per beat, stray readdatavalid in REQ
        idle_inputs();
        vals[0] = 32'hA0A0_0001;
        vals[1] = 32'hB0B0_0002;
        vals[2] = 32'hC0C0_0003;
        vals[3] = 32'hD0D0_0004;
        mem_mem_read   = 1'b1;
        mem_vector_op  = 1'b1;
        mem_reg_write  = 1'b1;
        mem_rd         = 5'd9;
        mem_result_src = 2'b01;
        mem_alu_result = 128'h300;
        tick();
        for (int i = 0; i < 4; i++) begin
            avm_waitrequest = 1'b1;
            exp_addr = 32'h300 + 32'(4 * i);
            check("vld_req_addr", 128'(avm_address), 128'(exp_addr));
            if (i == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = 32'hBAD0_BAD0;
            end
            tick();
            avm_readdatavalid = 1'b0;
            avm_waitrequest   = 1'b0;
            tick();
            avm_readdatavalid = 1'b1;
            avm_readdata      = vals[i];
            tick();
            avm_readdatavalid = 1'b0;
            avm_readdata      = 32'd0;
        end
        #1;
        check("vld_done_stall", 128'(mem_stall), 128'd0);
        check("vld_bubble", 128'(wb_reg_write), 128'd0);
        tick();
        check("vld_wb_result", wb_result, {vals[3], vals[2], vals[1], vals[0]});
        check("vld_wb_rd", 128'(wb_rd), 128'd9);
        check("vld_wb_we", 128'(wb_reg_write), 128'd1);
        idle_inputs();
        tick();
        check("vld_single_pulse", 128'(wb_reg_write), 128'd0);

        // JAL link value
        mem_reg_write  = 1'b1;
        mem_rd         = 5'd1;
        mem_result_src = 2'b10;
        mem_pc_plus_4  = 32'h44;
        mem_alu_result = 128'h999;
        tick();
        check("jal_wb_result", wb_result, 128'h44);
        check("jal_wb_rd", 128'(wb_rd), 128'd1);

        // Read and write together: only the write goes out
        idle_inputs();
        mem_mem_read   = 1'b1;
        mem_mem_write  = 1'b1;
        mem_alu_result = 128'h400;
        mem_write_data = 128'h55;
        rd_base = rd_acc;
        wr_base = wr_acc;
        tick();
        check("rw_write", 128'(avm_write), 128'd1);
        check("rw_read", 128'(avm_read), 128'd0);
        check("rw_addr", 128'(avm_address), 128'h400);
        check("rw_data", 128'(avm_writedata), 128'h55);
        tick();
        check("rw_done_stall", 128'(mem_stall), 128'd0);
        tick();
        idle_inputs();
        check("rw_read_count", 128'(rd_acc - rd_base), 128'd0);
        check("rw_write_count", 128'(wr_acc - wr_base), 128'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
